// File: rtl/hdmi_ctrl_pkg.sv
// Shared definitions for the HDMI scan controller: default 640x480@60
// timing, state encoding, pixel type and the colour-bar palette.
package hdmi_ctrl_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int PIX_W_DEF    = 12;
   typedef logic [PIX_W_DEF-1:0] pixel_t;

   // Scan state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_WAIT_FILL = 2'd1;
   localparam state_t ST_RUN       = 2'd2;
   localparam state_t ST_RESYNC    = 2'd3;

   // Colour-bar palette, {R,G,B} nibbles, left to right
   localparam pixel_t BAR_WHITE   = 12'hFFF;
   localparam pixel_t BAR_YELLOW  = 12'hFF0;
   localparam pixel_t BAR_CYAN    = 12'h0FF;
   localparam pixel_t BAR_GREEN   = 12'h0F0;
   localparam pixel_t BAR_MAGENTA = 12'hF0F;
   localparam pixel_t BAR_RED     = 12'hF00;
   localparam pixel_t BAR_BLUE    = 12'h00F;
   localparam pixel_t BAR_BLACK   = 12'h000;

   function automatic pixel_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = BAR_WHITE;
         3'd1:    bar_colour = BAR_YELLOW;
         3'd2:    bar_colour = BAR_CYAN;
         3'd3:    bar_colour = BAR_GREEN;
         3'd4:    bar_colour = BAR_MAGENTA;
         3'd5:    bar_colour = BAR_RED;
         3'd6:    bar_colour = BAR_BLUE;
         default: bar_colour = BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// Raster position counters with hold-at-origin, frame-wrap flag and
// combinational decode of active area and sync windows.
module hdmi_timing_counter #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HW       = 10,
   parameter int VW       = 10
) (
   input  logic          i_p_clk,
   input  logic          i_resetn,
   input  logic          i_hold,
   output logic [HW-1:0] o_h,
   output logic [VW-1:0] o_v,
   output logic          o_wrap,
   output logic          o_in_active,
   output logic          o_hsync_act,
   output logic          o_vsync_act
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          h_last_s, v_last_s;

   assign h_last_s    = (h_q == HW'(H_TOTAL - 1));
   assign v_last_s    = (v_q == VW'(V_TOTAL - 1));
   assign o_wrap      = h_last_s & v_last_s;
   assign o_in_active = (h_q < HW'(H_ACTIVE)) & (v_q < VW'(V_ACTIVE));
   assign o_hsync_act = (h_q >= HW'(H_ACTIVE + H_FP)) & (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign o_vsync_act = (v_q >= VW'(V_ACTIVE + V_FP)) & (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign o_h         = h_q;
   assign o_v         = v_q;

   // Next raster position: hold at origin, else advance h and carry into v
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (i_hold) begin
         h_d = HW'(0);
         v_d = VW'(0);
      end else if (h_last_s) begin
         h_d = HW'(0);
         if (v_last_s) begin
            v_d = VW'(0);
         end else begin
            v_d = v_q + VW'(1);
         end
      end else begin
         h_d = h_q + HW'(1);
      end
   end

   // Position registers
   always_ff @(posedge i_p_clk) begin
      if (!i_resetn) begin
         h_q <= HW'(0);
         v_q <= VW'(0);
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

endmodule

// File: rtl/hdmi_scan_ctrl.sv
// Scan controller in front of the HDMI output path: raster timing, FWFT
// FIFO pixel fetch, underflow detection and realignment to the next frame.
// Optional build macro TEST_PATTERN_EN adds i_pattern_sel and an 8-bar
// colour pattern that replaces FIFO pixels when selected.
module hdmi_scan_ctrl
   import hdmi_ctrl_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic SYNC_POL = 1'b0,
   parameter int   PIX_W    = PIX_W_DEF
) (
   input  logic             i_p_clk,
   input  logic             i_resetn,
   input  logic             i_enable,
   input  logic [PIX_W-1:0] i_fifo_data,
   input  logic             i_fifo_empty,
`ifdef TEST_PATTERN_EN
   input  logic             i_pattern_sel,
`endif
   input  logic             i_underflow_clr,
   output logic             o_fifo_rd,
   output logic [PIX_W-1:0] o_pixel,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_active_area,
   output logic             o_frame_start,
   output logic             o_underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   state_t           state_q, state_d;
   logic [PIX_W-1:0] pixel_q, pixel_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             active_q, active_d;
   logic             frame_start_q, frame_start_d;
   logic             underflow_q, underflow_d;

   logic [HW-1:0]    h_s;
   logic [VW-1:0]    v_s;
   logic             wrap_s, in_active_s, hsync_act_s, vsync_act_s;
   logic             timing_on_s, fetch_s, underflow_now_s, pat_on_s;

`ifdef TEST_PATTERN_EN
   localparam int    BAR_W = H_ACTIVE / 8;
   logic             pat_q, pat_d;
   logic [2:0]       bar_idx_s;

   assign pat_on_s  = pat_q;
   assign bar_idx_s = 3'(h_s / HW'(BAR_W));
`else
   assign pat_on_s  = 1'b0;
`endif

   // Counters only run while a frame is being scanned (RUN or RESYNC)
   assign timing_on_s     = (state_q == ST_RUN) | (state_q == ST_RESYNC);
   assign fetch_s         = (state_q == ST_RUN) & in_active_s & ~pat_on_s;
   assign underflow_now_s = fetch_s & i_fifo_empty;
   assign o_fifo_rd       = fetch_s & ~i_fifo_empty;

   hdmi_timing_counter #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .HW (HW), .VW (VW)
   ) u_timing (
      .i_p_clk     (i_p_clk),
      .i_resetn    (i_resetn),
      .i_hold      (~timing_on_s),
      .o_h         (h_s),
      .o_v         (v_s),
      .o_wrap      (wrap_s),
      .o_in_active (in_active_s),
      .o_hsync_act (hsync_act_s),
      .o_vsync_act (vsync_act_s)
   );

   // Scan FSM: start-up, free run, underflow recovery and frame-aligned stop
   always_comb begin
      state_d = state_q;
`ifdef TEST_PATTERN_EN
      pat_d   = pat_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_enable) begin
               state_d = ST_WAIT_FILL;
`ifdef TEST_PATTERN_EN
               pat_d   = i_pattern_sel;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_FILL: begin
            if (!i_fifo_empty || pat_on_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_WAIT_FILL;
            end
         end
         ST_RUN: begin
            if (underflow_now_s) begin
               state_d = ST_RESYNC;
            end else if (wrap_s) begin
               state_d = i_enable ? ST_RUN : ST_IDLE;
`ifdef TEST_PATTERN_EN
               pat_d   = i_pattern_sel;
`endif
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RESYNC: begin
            if (wrap_s) begin
               state_d = ST_WAIT_FILL;
`ifdef TEST_PATTERN_EN
               pat_d   = i_pattern_sel;
`endif
            end else begin
               state_d = ST_RESYNC;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output next values, decoded from the current counter state
   always_comb begin
      pixel_d = {PIX_W{1'b0}};
      if ((state_q == ST_RUN) && in_active_s) begin
`ifdef TEST_PATTERN_EN
         if (pat_on_s) begin
            pixel_d = PIX_W'(bar_colour(bar_idx_s));
         end else if (!i_fifo_empty) begin
            pixel_d = i_fifo_data;
         end else begin
            pixel_d = {PIX_W{1'b0}};
         end
`else
         if (!i_fifo_empty) begin
            pixel_d = i_fifo_data;
         end else begin
            pixel_d = {PIX_W{1'b0}};
         end
`endif
      end else begin
         pixel_d = {PIX_W{1'b0}};
      end
      active_d      = timing_on_s & in_active_s;
      hsync_d       = (timing_on_s & hsync_act_s) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (timing_on_s & vsync_act_s) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = timing_on_s & (h_s == HW'(0)) & (v_s == VW'(0));
      if (underflow_now_s) begin
         underflow_d = 1'b1;
      end else if (i_underflow_clr) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end
   end

   // State and output registers
   always_ff @(posedge i_p_clk) begin
      if (!i_resetn) begin
         state_q       <= ST_IDLE;
         pixel_q       <= {PIX_W{1'b0}};
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         active_q      <= 1'b0;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
`ifdef TEST_PATTERN_EN
         pat_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pixel_q       <= pixel_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
`ifdef TEST_PATTERN_EN
         pat_q         <= pat_d;
`endif
      end
   end

   assign o_pixel       = pixel_q;
   assign o_hsync       = hsync_q;
   assign o_vsync       = vsync_q;
   assign o_active_area = active_q;
   assign o_frame_start = frame_start_q;
   assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_hdmi_scan_ctrl.sv
// Directed bench for hdmi_scan_ctrl using a reduced raster
// (80 x 19 totals, 64 x 12 active) so whole frames stay short.
module tb_hdmi_scan_ctrl;
   localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = 80;
   localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = 19;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        clr = 1'b0;
   logic [11:0] fifo_word = 12'h123;
`ifdef TEST_PATTERN_EN
   logic        pattern_sel = 1'b0;
`endif
   logic        rd, hs, vs, act, fs, uf;
   logic [11:0] pix;
   int          total = 0;
   int          bad = 0;

   hdmi_scan_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .PIX_W(12)
   ) dut (
      .i_p_clk(clk), .i_resetn(resetn), .i_enable(enable),
      .i_fifo_data(fifo_word), .i_fifo_empty(fifo_empty),
`ifdef TEST_PATTERN_EN
      .i_pattern_sel(pattern_sel),
`endif
      .i_underflow_clr(clr), .o_fifo_rd(rd), .o_pixel(pix),
      .o_hsync(hs), .o_vsync(vs), .o_active_area(act),
      .o_frame_start(fs), .o_underflow(uf)
   );

   always #5 clk = ~clk;

   // FWFT FIFO model: head word advances on every pop
   always @(posedge clk) if (rd) fifo_word <= fifo_word + 12'd1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected {active, hsync, vsync, frame_start} for output index c
   function automatic logic [3:0] exp_timing(input int c);
      int h, v;
      h = c % HT;
      v = (c / HT) % VT;
      exp_timing = {(h < HA && v < VA), !(h >= HA + HF && h < HA + HF + HS),
                    !(v >= VA + VF && v < VA + VF + VS), (h == 0 && v == 0)};
   endfunction

   task automatic test_reset();
      resetn = 1'b0; enable = 1'b0; fifo_empty = 1'b1;
      step(); step(); step();
      total++; if ({pix, hs, vs, act, fs, uf, rd} !== {12'h000, 6'b110000}) begin
         bad++; $display("FAIL reset_values: got pix=%h hs=%b vs=%b act=%b fs=%b uf=%b rd=%b want 000 1 1 0 0 0 0",
                         pix, hs, vs, act, fs, uf, rd);
      end
      resetn = 1'b1;
      step(); step();
      total++; if ({hs, vs, act, rd} !== 4'b1100) begin
         bad++; $display("FAIL idle_hold: got hs=%b vs=%b act=%b rd=%b want 1 1 0 0", hs, vs, act, rd);
      end
   endtask

   task automatic test_first_pixel();
      fifo_empty = 1'b0;
      enable = 1'b1;
      step();
      total++; if (rd !== 1'b0) begin bad++; $display("FAIL start_rd_early: got %b want 0", rd); end
      step();
      total++; if (rd !== 1'b1) begin bad++; $display("FAIL start_rd: got %b want 1", rd); end
      step();
      total++; if ({act, fs, pix} !== {2'b11, 12'h123}) begin
         bad++; $display("FAIL first_pixel: got act=%b fs=%b pix=%h want 1 1 123", act, fs, pix);
      end
      step();
      total++; if ({fs, pix} !== {1'b0, 12'h124}) begin
         bad++; $display("FAIL second_pixel: got fs=%b pix=%h want 0 124", fs, pix);
      end
   endtask

   task automatic test_free_run();
      logic [11:0] exp_word;
      logic [11:0] exp_pix;
      bit          found;
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if (fs === 1'b1) begin found = 1'b1; break; end
      end
      total++; if (!found) begin bad++; $display("FAIL frame_start_timeout: got none want pulse"); end
      exp_word = 12'h423;
      for (int c = 0; c <= FRAME; c++) begin
         exp_pix = 12'h000;
         if (exp_timing(c)[3]) begin exp_pix = exp_word; exp_word = exp_word + 12'd1; end
         total++; if ({act, hs, vs, fs, pix} !== {exp_timing(c), exp_pix}) begin
            bad++; $display("FAIL free_run c=%0d: got act/hs/vs/fs=%b pix=%h want %b %h",
                            c, {act, hs, vs, fs}, pix, exp_timing(c), exp_pix);
         end
         if (c < FRAME) step();
      end
   endtask

   task automatic test_underflow();
      for (int c = 0; c <= FRAME + 1; c++) begin
         if (c < FRAME) begin
            total++; if ({hs, vs, fs} !== {exp_timing(c)[2:1], exp_timing(c)[0]}) begin
               bad++; $display("FAIL uf_syncs c=%0d: got hs/vs/fs=%b want %b", c, {hs, vs, fs},
                               {exp_timing(c)[2:1], exp_timing(c)[0]});
            end
         end
         if (c == 410) begin
            total++; if ({pix, uf} !== {12'h000, 1'b1}) begin
               bad++; $display("FAIL uf_pixel: got pix=%h uf=%b want 000 1", pix, uf);
            end
            fifo_empty = 1'b0;
         end
         if (c >= 411 && c < FRAME) begin
            total++; if (rd !== 1'b0) begin bad++; $display("FAIL uf_no_read c=%0d: got %b want 0", c, rd); end
         end
         if (c == FRAME) begin
            total++; if ({rd, hs, vs, fs} !== 4'b1110) begin
               bad++; $display("FAIL uf_refill: got rd/hs/vs/fs=%b want 1110", {rd, hs, vs, fs});
            end
         end
         if (c == FRAME + 1) begin
            total++; if ({fs, uf} !== 2'b11) begin
               bad++; $display("FAIL uf_realign: got fs=%b uf=%b want 1 1", fs, uf);
            end
         end
         if (c == 409) fifo_empty = 1'b1;
         if (c <= FRAME) step();
      end
   endtask

   task automatic test_enable_drop();
      for (int c = 0; c <= FRAME + 80; c++) begin
         if (c < FRAME) begin
            total++; if ({act, hs, vs, fs} !== exp_timing(c)) begin
               bad++; $display("FAIL drop_frame c=%0d: got %b want %b", c, {act, hs, vs, fs}, exp_timing(c));
            end
         end else begin
            total++; if ({act, hs, vs, fs, rd} !== 5'b01100) begin
               bad++; $display("FAIL drop_idle c=%0d: got act/hs/vs/fs/rd=%b want 01100", c, {act, hs, vs, fs, rd});
            end
         end
         if (c == 8 * HT) enable = 1'b0;
         step();
      end
   endtask

   task automatic test_reset_mid();
      enable = 1'b1;
      step(); step(); step();
      total++; if (fs !== 1'b1) begin bad++; $display("FAIL restart_fs: got %b want 1", fs); end
      for (int c = 0; c < 804; c++) step();
      resetn = 1'b0;
      step();
      total++; if ({pix, hs, vs, act, fs, uf, rd} !== {12'h000, 6'b110000}) begin
         bad++; $display("FAIL midframe_reset: got pix=%h hs=%b vs=%b act=%b fs=%b uf=%b rd=%b want 000 1 1 0 0 0 0",
                         pix, hs, vs, act, fs, uf, rd);
      end
      resetn = 1'b1;
      step();
      total++; if (rd !== 1'b0) begin bad++; $display("FAIL post_reset_wait: got rd=%b want 0", rd); end
      step();
      total++; if (rd !== 1'b1) begin bad++; $display("FAIL post_reset_run: got rd=%b want 1", rd); end
      step();
      total++; if (fs !== 1'b1) begin bad++; $display("FAIL post_reset_fs: got %b want 1", fs); end
   endtask

   task automatic test_underflow_clr();
      fifo_empty = 1'b1;
      step();
      total++; if ({uf, pix} !== {1'b1, 12'h000}) begin
         bad++; $display("FAIL clr_set: got uf=%b pix=%h want 1 000", uf, pix);
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      total++; if (uf !== 1'b0) begin bad++; $display("FAIL clr_clear: got %b want 0", uf); end
      step();
      total++; if (uf !== 1'b0) begin bad++; $display("FAIL clr_stays: got %b want 0", uf); end
      fifo_empty = 1'b0;
   endtask

`ifdef TEST_PATTERN_EN
   task automatic test_pattern();
      logic [11:0] exp_bar;
      resetn = 1'b0; enable = 1'b0;
      step();
      resetn = 1'b1; fifo_empty = 1'b1; pattern_sel = 1'b1; enable = 1'b1;
      step(); step(); step();
      for (int c = 0; c < HA; c++) begin
         exp_bar = 12'hxxx;
         if (c == 0)  exp_bar = 12'hFFF;
         if (c == 8)  exp_bar = 12'hFF0;
         if (c == 16) exp_bar = 12'h0FF;
         if (c == 56) exp_bar = 12'h000;
         if (c == 0 || c == 8 || c == 16 || c == 56) begin
            total++; if (pix !== exp_bar) begin
               bad++; $display("FAIL pattern_bar c=%0d: got %h want %h", c, pix, exp_bar);
            end
         end
         total++; if ({rd, uf} !== 2'b00) begin
            bad++; $display("FAIL pattern_no_fifo c=%0d: got rd=%b uf=%b want 0 0", c, rd, uf);
         end
         step();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_pixel();
      test_free_run();
      test_underflow();
      test_enable_drop();
      test_reset_mid();
      test_underflow_clr();
`ifdef TEST_PATTERN_EN
      test_pattern();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
